// File: rtl/remote_pkg.sv
// Definitions shared by the remote-control transmitter and receiver:
// FSM encodings, frame geometry and the frame builder.
package remote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } tx_state_e;

    localparam int FRAME_BITS       = 32;
    localparam int BIT_CLKS_DEFAULT = 8;
    localparam int GAP_BITS_DEFAULT = 2;

    // Field positions inside the 32-bit frame (bit 31 is the start marker).
    localparam int START_POS = 31;
    localparam int ADDR_MSB  = 30;
    localparam int ADDR_LSB  = 16;
    localparam int DATA_MSB  = 15;
    localparam int DATA_LSB  = 8;
    localparam int INV_MSB   = 7;
    localparam int INV_LSB   = 0;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [14:0] addr,
                                                          input logic [7:0]  code);
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[START_POS]         = 1'b0;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = code;
        f[INV_MSB:INV_LSB]   = ~code;
        return f;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts asynchronously, releases two Clock edges
// after Reset is removed.
module reset_sync (
    input  logic Clock,
    input  logic Reset,
    output logic rst_sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_sync_o = sync_q[1];

endmodule

// File: rtl/remote_transmitter.sv
// Serial remote-control transmitter: sends a 32-bit frame MSB first,
// BIT_CLKS cycles per bit, followed by GAP_BITS idle-high bit times.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | line high, waiting for Send; Done pulses on entry from GAP
// ST_SHIFT | shifting the latched frame out, bit 31 first
// ST_GAP   | line high, inter-frame spacing, still Busy
module remote_transmitter
    import remote_pkg::*;
#(
    parameter int BIT_CLKS = BIT_CLKS_DEFAULT,
    parameter int GAP_BITS = GAP_BITS_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Send,
    input  logic [7:0]  Tecla,
    input  logic [14:0] Address,
    output logic        Serial,
    output logic        Busy,
    output logic        Done
);

    localparam int GAP_CLKS = GAP_BITS * BIT_CLKS;
    localparam int BW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam bit HAS_GAP  = (GAP_CLKS > 0);

    localparam logic [BW-1:0] BIT_LOAD = BW'(BIT_CLKS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [4:0]    IDX_TOP  = 5'(FRAME_BITS - 1);

    logic                  rst_sync;
    tx_state_e             state_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] frame_d;
    logic [BW-1:0]         bit_tmr_q;
    logic [GW-1:0]         gap_tmr_q;
    logic [4:0]            idx_q;
    logic                  serial_q;
    logic                  busy_q;
    logic                  done_q;

    reset_sync u_reset_sync (
        .Clock      (Clock),
        .Reset      (Reset),
        .rst_sync_o (rst_sync)
    );

    assign frame_d = build_frame(Address, Tecla);

    // Timers count down and act on reaching zero; the frame is captured
    // once at acceptance so input changes while Busy are harmless.
    always_ff @(posedge Clock or posedge rst_sync) begin
        if (rst_sync) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            bit_tmr_q <= '0;
            gap_tmr_q <= '0;
            idx_q     <= '0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Send) begin
                        frame_q   <= frame_d;
                        serial_q  <= frame_d[FRAME_BITS-1];
                        bit_tmr_q <= BIT_LOAD;
                        idx_q     <= IDX_TOP;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_tmr_q == '0) begin
                        bit_tmr_q <= BIT_LOAD;
                        if (idx_q == '0) begin
                            serial_q <= 1'b1;
                            if (HAS_GAP) begin
                                gap_tmr_q <= GAP_LOAD;
                                state_q   <= ST_GAP;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            idx_q    <= idx_q - 5'd1;
                            serial_q <= frame_q[idx_q - 5'd1];
                        end
                    end else begin
                        bit_tmr_q <= bit_tmr_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_tmr_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_tmr_q <= gap_tmr_q - 1'b1;
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign Serial = serial_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_remote_transmitter.sv
// Self-checking bench for remote_transmitter: expected line/Busy/Done
// waveforms are derived from the frame layout and cycle arithmetic.
module tb_remote_transmitter;

    localparam int BC     = 8;
    localparam int GB     = 2;
    localparam int SHIFT  = 32 * BC;
    localparam int LAST   = SHIFT + GB * BC;
    localparam int PERIOD = LAST + 1;

    logic        Clock;
    logic        Reset;
    logic        Send;
    logic [7:0]  Tecla;
    logic [14:0] Address;
    logic        Serial;
    logic        Busy;
    logic        Done;

    int n_vec;
    int n_err;

    remote_transmitter #(.BIT_CLKS(BC), .GAP_BITS(GB)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Send    (Send),
        .Tecla   (Tecla),
        .Address (Address),
        .Serial  (Serial),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] exp_frame(input logic [14:0] a, input logic [7:0] t);
        return {1'b0, a, t, ~t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_serial", 32'(Serial), 32'd1);
            chk("idle_busy", 32'(Busy), 32'd0);
            chk("idle_done", 32'(Done), 32'd0);
            step();
        end
    endtask

    // Entered in cycle k+1 of an accepted frame; leaves in cycle k+274
    // (which is k'+1 of the next frame if next_send was set).
    task automatic frame_cycles(input logic [31:0] fr, input bit noisy, input bit hold,
                                input bit next_send, input logic [7:0] nt,
                                input logic [14:0] na);
        logic [31:0] rx;
        logic        es;
        rx = '0;
        for (int t = 1; t <= PERIOD; t++) begin
            es = (t <= SHIFT) ? fr[31 - (t - 1) / BC] : 1'b1;
            chk("serial", 32'(Serial), 32'(es));
            chk("busy", 32'(Busy), 32'(t <= LAST));
            chk("done", 32'(Done), 32'(t == PERIOD));
            if (t <= SHIFT && ((t - 1) % BC) == BC / 2)
                rx[31 - (t - 1) / BC] = Serial;
            if (t < PERIOD) begin
                if (noisy) begin
                    Send    = 1'($urandom);
                    Tecla   = 8'($urandom);
                    Address = 15'($urandom);
                end else begin
                    Send = hold;
                end
            end else begin
                Send    = next_send;
                Tecla   = nt;
                Address = na;
            end
            step();
        end
        chk("rx_frame", rx, fr);
        chk("rx_inverse", 32'(rx[7:0]), 32'(~rx[15:8] & 8'hFF));
    endtask

    task automatic release_and_send(input logic [7:0] t, input logic [14:0] a);
        Reset   = 1'b0;
        Send    = 1'b1;
        Tecla   = t;
        Address = a;
        step();
        chk("sync1_busy", 32'(Busy), 32'd0);
        chk("sync1_serial", 32'(Serial), 32'd1);
        step();
        chk("sync2_busy", 32'(Busy), 32'd0);
        chk("sync2_done", 32'(Done), 32'd0);
        step();
    endtask

    task automatic start_frame(input logic [7:0] t, input logic [14:0] a);
        Send    = 1'b1;
        Tecla   = t;
        Address = a;
        step();
    endtask

    initial begin
        logic [7:0]  t0;
        logic [7:0]  t1;
        logic [14:0] a0;
        logic [14:0] a1;
        bit          nx;

        n_vec   = 0;
        n_err   = 0;
        Reset   = 1'b1;
        Send    = 1'b0;
        Tecla   = 8'h00;
        Address = 15'h0000;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_serial", 32'(Serial), 32'd1);
            chk("rst_busy", 32'(Busy), 32'd0);
            chk("rst_done", 32'(Done), 32'd0);
            Send = 1'b1;
            step();
        end

        // Basic frame straight out of reset, Send held through the sync window.
        release_and_send(8'h5A, 15'h1234);
        frame_cycles(exp_frame(15'h1234, 8'h5A), 1'b0, 1'b0, 1'b0, 8'h00, 15'h0);
        chk_idle(5);

        // Send pulses and input churn while Busy must not disturb the frame.
        t0 = 8'($urandom);
        a0 = 15'($urandom);
        start_frame(t0, a0);
        frame_cycles(exp_frame(a0, t0), 1'b1, 1'b0, 1'b0, 8'h00, 15'h0);
        chk_idle(4);

        // Send held: three back-to-back frames, one every PERIOD cycles.
        start_frame(8'h3C, 15'h7001);
        for (int f = 0; f < 3; f++)
            frame_cycles(exp_frame(15'h7001, 8'h3C), 1'b0, 1'b1, (f < 2), 8'h3C, 15'h7001);
        chk_idle(PERIOD / 2);

        // Extreme codes, chained through the Done-cycle accept.
        start_frame(8'h00, 15'h0000);
        frame_cycles(exp_frame(15'h0000, 8'h00), 1'b0, 1'b0, 1'b1, 8'hFF, 15'h7FFF);
        frame_cycles(exp_frame(15'h7FFF, 8'hFF), 1'b0, 1'b0, 1'b0, 8'h00, 15'h0);
        chk_idle(3);

        // Reset in cycle k+100 aborts the frame immediately, no Done.
        start_frame(8'hA7, 15'h5555);
        Send = 1'b0;
        for (int t = 1; t < 100; t++) begin
            chk("pre_abort_busy", 32'(Busy), 32'd1);
            step();
        end
        Reset = 1'b1;
        #1;
        chk("abort_serial", 32'(Serial), 32'd1);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        step();
        chk("abort_hold_done", 32'(Done), 32'd0);
        release_and_send(8'h01, 15'h0ABC);
        frame_cycles(exp_frame(15'h0ABC, 8'h01), 1'b0, 1'b0, 1'b0, 8'h00, 15'h0);
        chk_idle(2);

        // Random frames, randomly chained or separated.
        t0 = 8'($urandom);
        a0 = 15'($urandom);
        start_frame(t0, a0);
        for (int f = 0; f < 4; f++) begin
            t1 = 8'($urandom);
            a1 = 15'($urandom);
            nx = 1'($urandom);
            frame_cycles(exp_frame(a0, t0), 1'b0, 1'b0, nx, t1, a1);
            if (!nx) begin
                chk_idle(3);
                start_frame(t1, a1);
            end
            t0 = t1;
            a0 = a1;
        end
        frame_cycles(exp_frame(a0, t0), 1'b0, 1'b0, 1'b0, 8'h00, 15'h0);
        chk_idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
